// File: rtl/fb_write_scheduler_pkg.sv
// Shared framebuffer definitions: geometry, colour indices and scheduler state encodings.
package fb_write_scheduler_pkg;

  localparam int FB_ADDR_W  = 19;
  localparam int FB_DATA_W  = 3;
  localparam int FB_NUM_PIX = 153600;

  localparam logic [FB_DATA_W-1:0] FB_COLOR_BLACK = 3'd0;
  localparam logic [FB_DATA_W-1:0] FB_COLOR_RED   = 3'd1;
  localparam logic [FB_DATA_W-1:0] FB_COLOR_GREEN = 3'd2;
  localparam logic [FB_DATA_W-1:0] FB_COLOR_BLUE  = 3'd4;
  localparam logic [FB_DATA_W-1:0] FB_COLOR_WHITE = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_GNT_TYP = 2'd2,
    S_GNT_DRW = 2'd3
  } sched_state_e;

  typedef enum logic {
    RR_TYP = 1'b0,
    RR_DRW = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address counter for the full-screen clear; done pulses one cycle after the last write is on the port.
module fb_clear_sweeper
  import fb_write_scheduler_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int FB_DEPTH = FB_NUM_PIX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic [ADDR_W-1:0] cnt;
  logic              last_q;

  assign addr = cnt;
  assign last = run && (cnt == LAST_ADDR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      last_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      last_q <= last;
      done   <= last_q;
      if (last)     cnt <= '0;
      else if (run) cnt <= cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Arbitrates the framebuffer write port between clear sweep, typer and drawer (round-robin, clear first).
// Optional FB_SCHED_STATS_EN adds per-requester write counters and an out-of-range drop counter.
module fb_write_scheduler
  import fb_write_scheduler_pkg::*;
#(
  parameter int                ADDR_W    = FB_ADDR_W,
  parameter int                DATA_W    = FB_DATA_W,
  parameter int                FB_DEPTH  = FB_NUM_PIX,
  parameter logic [DATA_W-1:0] CLR_COLOR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_done,
  input  logic              typ_req,
  output logic              typ_gnt,
  input  logic [ADDR_W-1:0] typ_waddr,
  input  logic [DATA_W-1:0] typ_wdata,
  input  logic              typ_we,
  input  logic              drw_req,
  output logic              drw_gnt,
  input  logic [ADDR_W-1:0] drw_waddr,
  input  logic [DATA_W-1:0] drw_wdata,
  input  logic              drw_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wenable,
  output logic              busy
`ifdef FB_SCHED_STATS_EN
  ,
  output logic [31:0]       typ_wr_cnt,
  output logic [31:0]       drw_wr_cnt,
  output logic [15:0]       oob_drop_cnt
`endif
);

  sched_state_e      state, state_nx;
  rr_sel_e           rr, rr_nx;
  logic              clr_pend;
  logic              sweep_last;
  logic [ADDR_W-1:0] sweep_addr;

  logic              src_act, src_we, in_range;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data;

  fb_clear_sweeper #(.ADDR_W(ADDR_W), .FB_DEPTH(FB_DEPTH)) u_sweep (
    .clock (clock),
    .reset (reset),
    .run   (state == S_CLEAR),
    .addr  (sweep_addr),
    .last  (sweep_last),
    .done  (clear_done)
  );

  assign typ_gnt = (state == S_GNT_TYP);
  assign drw_gnt = (state == S_GNT_DRW);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    unique case (state)
      S_IDLE: begin
        if (clear_req || clr_pend)                      state_nx = S_CLEAR;
        else if (typ_req && (!drw_req || rr == RR_TYP)) state_nx = S_GNT_TYP;
        else if (drw_req)                               state_nx = S_GNT_DRW;
      end
      S_CLEAR:   if (sweep_last) state_nx = S_IDLE;
      S_GNT_TYP: if (!typ_req) begin state_nx = S_IDLE; rr_nx = RR_DRW; end
      S_GNT_DRW: if (!drw_req) begin state_nx = S_IDLE; rr_nx = RR_TYP; end
      default:   state_nx = S_IDLE;
    endcase
  end

  // A requester only drives the port while it still holds req; its release cycle writes nothing.
  always_comb begin
    src_act  = 1'b0;
    src_we   = 1'b0;
    src_addr = typ_waddr;
    src_data = typ_wdata;
    if (state == S_GNT_TYP) begin
      src_act = typ_req;
      src_we  = typ_we;
    end else if (state == S_GNT_DRW) begin
      src_act  = drw_req;
      src_we   = drw_we;
      src_addr = drw_waddr;
      src_data = drw_wdata;
    end
  end

  assign in_range = (src_addr < ADDR_W'(FB_DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr       <= RR_TYP;
      clr_pend <= 1'b0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
      if (state == S_IDLE)                  clr_pend <= 1'b0;
      else if (clear_req && state != S_CLEAR) clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_wenable <= 1'b0;
    end else if (state == S_CLEAR) begin
      mem_waddr   <= sweep_addr;
      mem_wdata   <= CLR_COLOR;
      mem_wenable <= 1'b1;
    end else if (src_act) begin
      mem_waddr   <= src_addr;
      mem_wdata   <= src_data;
      mem_wenable <= src_we && in_range;
    end else begin
      mem_wenable <= 1'b0;
    end
  end

`ifdef FB_SCHED_STATS_EN
  logic wr_ok, typ_acc, drw_acc, oob_drop;
  assign wr_ok    = src_act && src_we && in_range;
  assign typ_acc  = wr_ok && (state == S_GNT_TYP);
  assign drw_acc  = wr_ok && (state == S_GNT_DRW);
  assign oob_drop = src_act && src_we && !in_range;

  // A write landing on the clearing edge is still counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      typ_wr_cnt   <= '0;
      drw_wr_cnt   <= '0;
      oob_drop_cnt <= '0;
    end else if (clear_done) begin
      typ_wr_cnt   <= 32'(typ_acc);
      drw_wr_cnt   <= 32'(drw_acc);
      oob_drop_cnt <= 16'(oob_drop);
    end else begin
      if (typ_acc  && typ_wr_cnt   != '1) typ_wr_cnt   <= typ_wr_cnt   + 32'd1;
      if (drw_acc  && drw_wr_cnt   != '1) drw_wr_cnt   <= drw_wr_cnt   + 32'd1;
      if (oob_drop && oob_drop_cnt != '1) oob_drop_cnt <= oob_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Randomized + directed bench for fb_write_scheduler against a cycle-level ownership model.
module tb_fb_write_scheduler;
  localparam int AW = 19, DW = 3, DEPTH = 1000;

  logic clock = 1'b0, reset = 1'b1;
  logic clear_req = 1'b0, typ_req = 1'b0, typ_we = 1'b0, drw_req = 1'b0, drw_we = 1'b0;
  logic [AW-1:0] typ_waddr = '0, drw_waddr = '0;
  logic [DW-1:0] typ_wdata = '0, drw_wdata = '0;
  logic clear_done, typ_gnt, drw_gnt, mem_wenable, busy;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
`ifdef FB_SCHED_STATS_EN
  logic [31:0] typ_wr_cnt, drw_wr_cnt;
  logic [15:0] oob_drop_cnt;
`endif

  int n_checks = 0, n_err = 0;
  bit chk_en = 1'b0;

  fb_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH), .CLR_COLOR(3'b000)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .clear_done(clear_done),
    .typ_req(typ_req), .typ_gnt(typ_gnt), .typ_waddr(typ_waddr), .typ_wdata(typ_wdata), .typ_we(typ_we),
    .drw_req(drw_req), .drw_gnt(drw_gnt), .drw_waddr(drw_waddr), .drw_wdata(drw_wdata), .drw_we(drw_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .busy(busy)
`ifdef FB_SCHED_STATS_EN
    , .typ_wr_cnt(typ_wr_cnt), .drw_wr_cnt(drw_wr_cnt), .oob_drop_cnt(oob_drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: who owns the port (0 none, 1 clear, 2 typer, 3 drawer) and what the port shows.
  int m_own, m_cnt, m_rr, m_typ, m_drw, m_oob;
  bit m_pend, m_wrap, m_done, e_wen;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_rr = 0; m_pend = 0; m_wrap = 0; m_done = 0;
    e_wen = 0; e_waddr = '0; e_wdata = '0; m_typ = 0; m_drw = 0; m_oob = 0;
  endtask

  task automatic model_step();
    bit nw, rq, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    nw = 0;
    if (m_done) begin m_typ = 0; m_drw = 0; m_oob = 0; end
    if (m_own == 0) begin
      e_wen = 0;
      if (clear_req || m_pend) begin m_own = 1; m_pend = 0; end
      else if (typ_req && (!drw_req || m_rr == 0)) m_own = 2;
      else if (drw_req) m_own = 3;
    end else if (m_own == 1) begin
      e_waddr = AW'(m_cnt); e_wdata = '0; e_wen = 1;
      if (m_cnt == DEPTH - 1) begin m_own = 0; m_cnt = 0; nw = 1; end
      else m_cnt++;
    end else begin
      rq = (m_own == 2) ? typ_req : drw_req;
      we = (m_own == 2) ? typ_we : drw_we;
      a  = (m_own == 2) ? typ_waddr : drw_waddr;
      d  = (m_own == 2) ? typ_wdata : drw_wdata;
      if (clear_req) m_pend = 1;
      if (rq) begin
        e_waddr = a; e_wdata = d; e_wen = we && (a < DEPTH);
        if (we && a >= DEPTH) m_oob++;
        else if (we && m_own == 2) m_typ++;
        else if (we) m_drw++;
      end else begin
        e_wen = 0; m_rr = (m_own == 2) ? 1 : 0; m_own = 0;
      end
    end
    m_done = m_wrap;
    m_wrap = nw;
  endtask

  initial forever begin
    @(negedge clock);
    if (!reset) model_reset();
    if (chk_en) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(e_waddr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("mem_wenable", 32'(mem_wenable), 32'(e_wen));
      chk("typ_gnt", 32'(typ_gnt), 32'(m_own == 2));
      chk("drw_gnt", 32'(drw_gnt), 32'(m_own == 3));
      chk("busy", 32'(busy), 32'(m_own != 0));
      chk("clear_done", 32'(clear_done), 32'(m_done));
`ifdef FB_SCHED_STATS_EN
      chk("typ_wr_cnt", typ_wr_cnt, m_typ);
      chk("drw_wr_cnt", drw_wr_cnt, m_drw);
      chk("oob_drop_cnt", 32'(oob_drop_cnt), m_oob);
`endif
    end
    if (reset) model_step();
  end

  task automatic set_req(input int which, input bit v);
    if (which == 0) typ_req = v; else drw_req = v;
    if (!v) begin if (which == 0) typ_we = 0; else drw_we = 0; end
  endtask

  task automatic drive_wr(input int which);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit w;
    a = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, 40)) : AW'($urandom_range(0, DEPTH - 1));
    d = DW'($urandom_range(0, 7));
    w = ($urandom_range(0, 3) != 0);
    if (which == 0) begin typ_waddr = a; typ_wdata = d; typ_we = w; end
    else begin drw_waddr = a; drw_wdata = d; drw_we = w; end
  endtask

  task automatic requester(input int which, input int bursts);
    for (int b = 0; b < bursts; b++) begin
      bit got;
      int len;
      got = 0;
      repeat ($urandom_range(0, 6)) tick();
      set_req(which, 1);
      for (int k = 0; k < 4 * DEPTH; k++) begin
        tick();
        if ((which == 0) ? typ_gnt : drw_gnt) begin got = 1; break; end
      end
      chk("grant_wait", 32'(got), 1);
      if (got) begin
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin drive_wr(which); tick(); end
      end
      set_req(which, 0);
      tick();
    end
  endtask

  // Issues a clear pulse and checks the full sweep; returns drw_gnt seen with clear_done.
  task automatic clear_sweep(input bit pulse, output bit drw_at_done);
    int nwr, bad, last_c, done_c;
    nwr = 0; bad = 0; last_c = -1; done_c = -1; drw_at_done = 0;
    if (pulse) begin clear_req = 1; tick(); clear_req = 0; end
    for (int c = 0; c < DEPTH + 20; c++) begin
      tick();
      if (mem_wenable) begin
        if (mem_waddr != AW'(nwr) || mem_wdata != 0) bad++;
        nwr++; last_c = c;
      end
      if (clear_done) begin done_c = c; drw_at_done = drw_gnt; break; end
    end
    chk("clear_writes", nwr, DEPTH);
    chk("clear_order", bad, 0);
    chk("clear_done_seen", 32'(done_c >= 0), 1);
    chk("clear_done_lat", done_c - last_c, 1);
  endtask

  initial begin
    bit dg;
    #2 reset = 0;
    chk_en = 1;
    repeat (3) tick();
    chk("rst_wen", 32'(mem_wenable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_waddr", 32'(mem_waddr), 0);
    chk("rst_done", 32'(clear_done), 0);
    reset = 1;
    tick();

    clear_sweep(1, dg);

    // Typer burst: grant one cycle after req, writes appear one cycle after presentation.
    typ_req = 1; tick();
    chk("typ_gnt_lat", 32'(typ_gnt), 1);
    for (int i = 0; i < 10; i++) begin
      typ_waddr = AW'(100 + i); typ_wdata = DW'(i); typ_we = 1; tick();
      chk("typ_burst_addr", 32'(mem_waddr), 100 + i);
      chk("typ_burst_wen", 32'(mem_wenable), 1);
    end
    set_req(0, 0); tick();
    chk("typ_release", 32'(typ_gnt), 0);
    chk("typ_release_wen", 32'(mem_wenable), 0);

    // Both request out of reset: typer wins, drawer after one idle cycle.
    reset = 0; tick(); reset = 1; tick();
    typ_req = 1; drw_req = 1; tick();
    chk("rr_first_typ", 32'(typ_gnt), 1);
    chk("rr_first_drw", 32'(drw_gnt), 0);
    typ_waddr = 7; typ_we = 1; tick();
    set_req(0, 0); tick();
    chk("gap_busy", 32'(busy), 0);
    tick();
    chk("rr_then_drw", 32'(drw_gnt), 1);
    drw_waddr = AW'(DEPTH); drw_wdata = 3; drw_we = 1; tick();
    chk("oob_wen", 32'(mem_wenable), 0);
`ifdef FB_SCHED_STATS_EN
    chk("oob_cnt", 32'(oob_drop_cnt), 1);
`endif
    set_req(1, 0); tick();

    // Clear requested mid-grant runs before the waiting drawer.
    typ_req = 1; tick();
    drw_req = 1; clear_req = 1; typ_waddr = 20; typ_we = 1; tick();
    clear_req = 0; set_req(0, 0); tick();
    tick();
    chk("pend_clear_busy", 32'(busy), 1);
    chk("pend_clear_nodrw", 32'(drw_gnt), 0);
    clear_sweep(0, dg);
    chk("drw_after_clear", 32'(dg), 1);
    set_req(1, 0); tick();

    // Reset in the middle of a clear abandons it.
    clear_req = 1; tick(); clear_req = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mem_wenable && mem_waddr == AW'(500)) break;
      tick();
    end
    chk("reached_500", 32'(mem_waddr), 500);
    reset = 0; #1;
    chk("async_wen", 32'(mem_wenable), 0);
    chk("async_addr", 32'(mem_waddr), 0);
    chk("async_busy", 32'(busy), 0);
    tick(); tick(); reset = 1;
    for (int k = 0; k < 20; k++) begin tick(); chk("no_resume", 32'(mem_wenable | busy), 0); end

    // Random traffic with occasional clears.
    fork
      requester(0, 25);
      requester(1, 25);
      begin
        repeat (3) begin
          repeat ($urandom_range(100, 400)) tick();
          clear_req = 1; tick(); clear_req = 0;
        end
      end
    join
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
